aha_apb_master_bridge: RTL and testbench
========================================

AHA_APB_MASTER_BRIDGE -- requirements
Module: aha_apb_master_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max PCLKEN-qualified ACCESS cycles waiting for PREADY (range 1..65535; used only with REQ-027 macro).
REQ-002 ACLK  in  1  sole clock; all state updates on rising edge.
REQ-003 ARESETn  in  1  reset; asynchronous assert, active-low.
REQ-004 PCLKEN  in  1  APB clock enable; APB phases advance only in cycles with PCLKEN=1.
REQ-005 REQ_VALID  in  1  request offered.
REQ-006 REQ_READY  out  1  request accepted when REQ_VALID&REQ_READY.
REQ-007 REQ_WRITE  in  1  1=write, 0=read.
REQ-008 REQ_ADDR  in  12  APB byte address.
REQ-009 REQ_WDATA  in  32  write data.
REQ-010 RSP_VALID  out  1  response available.
REQ-011 RSP_READY  in  1  response consumed when RSP_VALID&RSP_READY.
REQ-012 RSP_RDATA  out  32  read data (0 for writes and timeouts).
REQ-013 RSP_ERR  out  1  PSLVERR or timeout.
REQ-014 PADDR  out  12; PSEL  out  1; PENABLE  out  1; PWRITE  out  1; PWDATA  out  32  APB requester outputs.
REQ-015 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB completer inputs.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
REQ-017 IDLE: REQ_READY=1, PSEL=0, PENABLE=0; on REQ_VALID handshake capture REQ_WRITE/ADDR/WDATA, go SETUP next cycle (PCLKEN ignored for acceptance).
REQ-018 SETUP: PSEL=1, PENABLE=0, REQ_READY=0; PADDR/PWRITE from captured request; PWDATA=captured data for writes, 0 for reads; if PCLKEN=1 go ACCESS, else stay.
REQ-019 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable, identical to SETUP.
REQ-020 ACCESS completes only in a cycle with PCLKEN=1 and PREADY=1: register RSP_RDATA=PRDATA for reads (0 for writes), RSP_ERR=PSLVERR, go RESP; PREADY/PSLVERR/PRDATA ignored when PCLKEN=0.
REQ-021 RESP: PSEL=0, PENABLE=0, RSP_VALID=1, RSP_RDATA/RSP_ERR stable; on RSP_READY go IDLE; RSP_VALID drops the following cycle.
REQ-022 No new request accepted before response handshake (single outstanding transfer); no combinational path REQ_VALID->REQ_READY or RSP_READY->REQ_READY.
REQ-023 Latency with PCLKEN=1, PREADY=1 on first ACCESS cycle: accept cycle 0, SETUP cycle 1, ACCESS cycle 2, RSP_VALID cycle 3; throughput one transfer per 4 cycles with RSP_READY=1.
REQ-024 Outside SETUP/ACCESS, PADDR/PWRITE/PWDATA hold last driven values; only PSEL/PENABLE indicate activity.
REQ-025 RSP_VALID and RSP_ERR are registered outputs; APB outputs are registered (no glitches).

Reset
REQ-026 ARESETn low: state IDLE, REQ_READY=0 while in reset then 1 from first cycle after deassert; PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR=0; PADDR, PWDATA, RSP_RDATA=0; timeout counter=0; in-flight transfer discarded, no response produced.

Configuration
REQ-027 Macro AHA_APB_MASTER_TIMEOUT_EN defined: 16-bit counter clears on SETUP->ACCESS, increments on each PCLKEN=1 ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES (and PREADY=0) go RESP with RSP_ERR=1, RSP_RDATA=0, PSEL/PENABLE deasserted next cycle; PREADY=1 in the same cycle wins (normal completion).
REQ-028 Macro undefined: no counter instantiated; ACCESS waits indefinitely for PREADY; TIMEOUT_CYCLES has no effect.

Verification
REQ-029 PCLKEN=1, write 0x010 data 0xDEADBEEF, PREADY=1 -> PSEL cycle 1-2, PENABLE cycle 2, PWDATA=0xDEADBEEF, RSP_VALID cycle 3, RSP_ERR=0, RSP_RDATA=0.
REQ-030 Read 0x024, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678, PSLVERR=1 -> RSP_RDATA=0x12345678, RSP_ERR=1, PADDR stable throughout.
REQ-031 PCLKEN toggling 1-in-3, read with PREADY=1 -> SETUP and ACCESS each last until a PCLKEN=1 cycle; PREADY sampled only on PCLKEN=1.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> RSP_ERR=1, RSP_RDATA=0 after 4 qualified ACCESS cycles; without macro, RSP_VALID never asserts.
REQ-033 RSP_READY held 0 for 5 cycles with REQ_VALID=1 -> REQ_READY=0 and PSEL=0 throughout; ARESETn pulsed during ACCESS -> all outputs per REQ-026, no response.

Source files
------------

// File: rtl/aha_apb_master_bridge.sv
// aha_apb_master_bridge: single-outstanding request/response to APB requester bridge.
// Four-state FSM (IDLE, SETUP, ACCESS, RESP); APB phases advance only on PCLKEN.
// All outputs come straight from flops, so nothing combinational reaches a port.
// Optional feature: define AHA_APB_MASTER_TIMEOUT_EN to add a 16-bit ACCESS
// timeout counter that ends a stalled transfer with RSP_ERR=1 after
// TIMEOUT_CYCLES PCLKEN-qualified wait cycles.
module aha_apb_master_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        PCLKEN,
   // request channel
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WRITE,
   input  logic [11:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   // response channel
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   // APB requester
   output logic [11:0] PADDR,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [11:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        timeout_hit;

`ifdef AHA_APB_MASTER_TIMEOUT_EN
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   // Counter restarts on SETUP->ACCESS and counts qualified ACCESS cycles without PREADY.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if ((state_q == ST_SETUP) && PCLKEN) begin
         tmo_cnt_d = 16'd0;
      end else if ((state_q == ST_ACCESS) && PCLKEN && !PREADY) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
   end

   // Timeout counter register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         tmo_cnt_q <= 16'd0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // Fires in the qualified wait cycle that brings the count up to the limit;
   // a PREADY in that same cycle takes priority in the FSM.
   assign timeout_hit = (state_q == ST_ACCESS) && PCLKEN && !PREADY &&
                        ((tmo_cnt_q + 16'd1) == TMO_LIMIT);
`else
   // Without the timeout feature ACCESS simply waits for PREADY.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_hit        = 1'b0;
`endif

   // Next-state and registered-output logic; every _d defaults to hold.
   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            // Acceptance does not wait for PCLKEN; only APB phases do.
            if (REQ_VALID && req_ready_q) begin
               state_d  = ST_SETUP;
               pwrite_d = REQ_WRITE;
               paddr_d  = REQ_ADDR;
               pwdata_d = REQ_WRITE ? REQ_WDATA : 32'd0;
            end
         end
         ST_SETUP: begin
            if (PCLKEN) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (PCLKEN && PREADY) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
               rsp_err_d   = PSLVERR;
            end else if (timeout_hit) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b1;
            end
         end
         ST_RESP: begin
            if (RSP_READY) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flag outputs are decoded from the next state so they line up with it.
      req_ready_d = (state_d == ST_IDLE);
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d   = (state_d == ST_ACCESS);
   end

   // State and output registers; reset discards any in-flight transfer.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 12'd0;
         pwdata_q    <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign REQ_READY = req_ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ERR   = rsp_err_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_aha_apb_master_bridge.sv
// Testbench for aha_apb_master_bridge: directed vectors, scoreboard queue of
// expected responses, monitor pops on every response handshake.
module tb_aha_apb_master_bridge;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        PCLKEN;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WRITE;
   logic [11:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic [11:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // {err, rdata}
   logic [32:0] mon_e;

   always #5 ACLK = ~ACLK;

   aha_apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .PCLKEN(PCLKEN),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
      .RSP_ERR(RSP_ERR),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   // Control snapshot: {REQ_READY, PSEL, PENABLE, RSP_VALID}
   function automatic logic [31:0] ctl();
      return {28'd0, REQ_READY, PSEL, PENABLE, RSP_VALID};
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic mid();
      @(negedge ACLK);
   endtask

   task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
      REQ_VALID = 1'b1;
      REQ_WRITE = wr;
      REQ_ADDR  = addr;
      REQ_WDATA = wd;
      $display("req %s addr=0x%03h wdata=0x%08h", wr ? "WR" : "RD", addr, wd);
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_ctl"}, ctl(), 32'h0);
      chk({nm, "_wr_err"}, {30'd0, PWRITE, RSP_ERR}, 32'h0);
      chk({nm, "_paddr"}, {20'd0, PADDR}, 32'h0);
      chk({nm, "_pwdata"}, PWDATA, 32'h0);
      chk({nm, "_rdata"}, RSP_RDATA, 32'h0);
   endtask

   // Scoreboard monitor: every response handshake must match the oldest expectation.
   always @(negedge ACLK) begin
      if (ARESETn === 1'b1 && RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got rdata=0x%08h err=%0b required no response",
                     RSP_RDATA, RSP_ERR);
         end else begin
            mon_e = exp_q.pop_front();
            $display("rsp rdata=0x%08h err=%0b (expected 0x%08h err=%0b)",
                     RSP_RDATA, RSP_ERR, mon_e[31:0], mon_e[32]);
            chk("rsp_rdata", RSP_RDATA, mon_e[31:0]);
            chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, mon_e[32]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      ARESETn   = 1'b0;
      PCLKEN    = 1'b1;
      REQ_VALID = 1'b0;
      REQ_WRITE = 1'b0;
      REQ_ADDR  = 12'h0;
      REQ_WDATA = 32'h0;
      RSP_READY = 1'b1;
      PRDATA    = 32'h0;
      PREADY    = 1'b1;
      PSLVERR   = 1'b0;

      // Reset state
      repeat (2) @(posedge ACLK);
      mid();
      check_all_zero("rst");
      tick();
      ARESETn = 1'b1;
      tick();
      mid();
      chk("ready_after_rst", ctl(), 32'h8);

      // Write 0x010 / 0xDEADBEEF, zero-wait completer
      tick();
      issue(1'b1, 12'h010, 32'hDEADBEEF);
      exp_q.push_back({1'b0, 32'h0});
      mid();
      chk("t1_c0_ctl", ctl(), 32'h8);
      tick();
      REQ_VALID = 1'b0;
      mid();
      chk("t1_c1_ctl", ctl(), 32'h4);
      chk("t1_c1_paddr", {20'd0, PADDR}, 32'h010);
      chk("t1_c1_pwrite", {31'd0, PWRITE}, 32'h1);
      chk("t1_c1_pwdata", PWDATA, 32'hDEADBEEF);
      tick();
      mid();
      chk("t1_c2_ctl", ctl(), 32'h6);
      chk("t1_c2_pwdata", PWDATA, 32'hDEADBEEF);
      tick();
      mid();
      chk("t1_c3_ctl", ctl(), 32'h1);
      tick();
      mid();
      chk("t1_c4_ctl", ctl(), 32'h8);

      // Read 0x024, three wait states, then PSLVERR with data
      for (int k = 0; k <= 7; k++) begin
         tick();
         if (k == 0) begin
            issue(1'b0, 12'h024, 32'hFFFF_FFFF);
            exp_q.push_back({1'b1, 32'h12345678});
            PREADY = 1'b0;
         end
         if (k == 1) REQ_VALID = 1'b0;
         if (k == 5) begin
            PREADY  = 1'b1;
            PRDATA  = 32'h12345678;
            PSLVERR = 1'b1;
         end
         if (k == 6) PSLVERR = 1'b0;
         mid();
         chk($sformatf("t2_c%0d_ctl", k), ctl(),
             (k == 0 || k == 7) ? 32'h8 : (k == 1) ? 32'h4 : (k <= 5) ? 32'h6 : 32'h1);
         if (k >= 1 && k <= 5) chk($sformatf("t2_c%0d_paddr", k), {20'd0, PADDR}, 32'h024);
         if (k == 1) chk("t2_c1_pwdata", PWDATA, 32'h0);
      end

      // PCLKEN high one cycle in three; completer signals are noise while PCLKEN=0
      for (int k = 0; k <= 7; k++) begin
         tick();
         PCLKEN  = (k % 3 == 2) || (k == 7);
         PREADY  = 1'b1;
         PSLVERR = ~PCLKEN;
         PRDATA  = PCLKEN ? 32'hCAFE0031 : 32'hBAD0BAD0;
         if (k == 0) begin
            issue(1'b0, 12'h3FC, 32'h0);
            exp_q.push_back({1'b0, 32'hCAFE0031});
         end
         if (k == 1) REQ_VALID = 1'b0;
         mid();
         chk($sformatf("t3_c%0d_ctl", k), ctl(),
             (k == 0 || k == 7) ? 32'h8 : (k <= 2) ? 32'h4 : (k <= 5) ? 32'h6 : 32'h1);
      end
      PSLVERR = 1'b0;

      // PREADY stuck low
      tick();
      PCLKEN = 1'b1;
      PREADY = 1'b0;
      issue(1'b1, 12'h100, 32'h5A5A0005);
`ifdef AHA_APB_MASTER_TIMEOUT_EN
      exp_q.push_back({1'b1, 32'h0});
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) REQ_VALID = 1'b0;
         mid();
         chk($sformatf("t4_c%0d_ctl", k), ctl(),
             (k == 1) ? 32'h4 : (k <= 5) ? 32'h6 : (k == 6) ? 32'h1 : 32'h8);
      end
      PREADY = 1'b1;
`else
      exp_q.push_back({1'b0, 32'h0});
      seen = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 1) REQ_VALID = 1'b0;
         mid();
         if (RSP_VALID !== 1'b0) seen++;
      end
      chk("t4_no_rsp_cycles", seen, 32'h0);
      chk("t4_stall_ctl", ctl(), 32'h6);
      tick();
      PREADY = 1'b1;
      mid();
      chk("t4_release_ctl", ctl(), 32'h6);
      tick();
      mid();
      chk("t4_resp_ctl", ctl(), 32'h1);
      tick();
      mid();
      chk("t4_idle_ctl", ctl(), 32'h8);
`endif

      // Response back-pressure with a new request waiting
      for (int k = 0; k <= 9; k++) begin
         tick();
         if (k == 0) begin
            issue(1'b0, 12'h020, 32'h0);
            PREADY  = 1'b1;
            PSLVERR = 1'b0;
            PRDATA  = 32'hA5A50001;
            exp_q.push_back({1'b0, 32'hA5A50001});
         end
         if (k == 1) REQ_ADDR = 12'h7FF;
         if (k == 3) begin
            RSP_READY = 1'b0;
            PRDATA    = 32'h0BADF00D;
         end
         if (k == 8) begin
            RSP_READY = 1'b1;
            REQ_VALID = 1'b0;
         end
         mid();
         chk($sformatf("t5_c%0d_ctl", k), ctl(),
             (k == 0 || k == 9) ? 32'h8 : (k == 1) ? 32'h4 : (k == 2) ? 32'h6 : 32'h1);
         if (k >= 3 && k <= 8) chk($sformatf("t5_c%0d_rdata", k), RSP_RDATA, 32'hA5A50001);
      end

      // Reset pulsed during ACCESS: everything clears, no response follows
      for (int k = 0; k <= 2; k++) begin
         tick();
         if (k == 0) begin
            issue(1'b1, 12'hABC, 32'h13579BDF);
            PREADY = 1'b0;
         end
         if (k == 1) REQ_VALID = 1'b0;
         mid();
      end
      chk("t6_access_ctl", ctl(), 32'h6);
      chk("t6_access_pwdata", PWDATA, 32'h13579BDF);
      tick();
      ARESETn = 1'b0;
      mid();
      check_all_zero("t6_rst");
      tick();
      tick();
      ARESETn = 1'b1;
      PREADY  = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         mid();
         if (RSP_VALID !== 1'b0 || PSEL !== 1'b0) seen++;
      end
      chk("t6_no_activity", seen, 32'h0);
      chk("t6_idle_ctl", ctl(), 32'h8);
      chk("sb_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
